// File: rtl/sort4_3bit_ctrl.sv
// Four-element 3-bit bubble sorter with early termination.
// One shared comparator makes one ordering decision per cycle.

module comparator_3bit (
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic       lt,
  output logic       gt,
  output logic       eq
);
  assign lt = a < b;
  assign gt = a > b;
  assign eq = a == b;
endmodule

module sort4_3bit_ctrl #(
  parameter int unsigned ASCEND = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] din0,
  input  logic [2:0] din1,
  input  logic [2:0] din2,
  input  logic [2:0] din3,
  output logic       busy,
  output logic       done,
  output logic [2:0] dout0,
  output logic [2:0] dout1,
  output logic [2:0] dout2,
  output logic [2:0] dout3,
  output logic [2:0] swap_count
);

  typedef enum logic [1:0] {StIdle, StSort, StDone} state_e;

  state_e           state_q, state_d;
  logic [3:0][2:0]  w_q, w_sw;
  logic [3:0][2:0]  dout_q;
  logic [1:0]       pass_q, pair_q, pair_r;
  logic [2:0]       swap_cnt_q, cnt_next, swap_count_q;
  logic             pass_swap_q;
  logic [2:0]       left, right;
  logic             cmp_lt, cmp_gt, cmp_eq;
  logic             do_swap, last_pair, finish;

  assign pair_r = pair_q + 2'd1;
  assign left   = w_q[pair_q];
  assign right  = w_q[pair_r];

  comparator_3bit u_cmp (
    .a  (left),
    .b  (right),
    .lt (cmp_lt),
    .gt (cmp_gt),
    .eq (cmp_eq)
  );

  // eq never swaps, which keeps the sort stable
  assign do_swap   = (state_q == StSort) && !cmp_eq && ((ASCEND != 0) ? cmp_gt : cmp_lt);
  assign last_pair = (pair_q == (2'd2 - pass_q));
  assign finish    = (state_q == StSort) && last_pair &&
                     (!(pass_swap_q || do_swap) || (pass_q == 2'd2));
  assign cnt_next  = swap_cnt_q + {2'b00, do_swap};

  always_comb begin
    w_sw = w_q;
    if (do_swap) begin
      w_sw[pair_q] = right;
      w_sw[pair_r] = left;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StSort;
      StSort:  if (finish) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q          <= '0;
      dout_q       <= '0;
      pass_q       <= '0;
      pair_q       <= '0;
      swap_cnt_q   <= '0;
      swap_count_q <= '0;
      pass_swap_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            w_q         <= {din3, din2, din1, din0};
            pass_q      <= '0;
            pair_q      <= '0;
            swap_cnt_q  <= '0;
            pass_swap_q <= 1'b0;
          end
        end
        StSort: begin
          w_q        <= w_sw;
          swap_cnt_q <= cnt_next;
          if (last_pair) begin
            pass_q      <= pass_q + 2'd1;
            pair_q      <= '0;
            pass_swap_q <= 1'b0;
          end else begin
            pair_q      <= pair_r;
            pass_swap_q <= pass_swap_q | do_swap;
          end
          if (finish) begin
            dout_q       <= w_sw;
            swap_count_q <= cnt_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout0      = dout_q[0];
  assign dout1      = dout_q[1];
  assign dout2      = dout_q[2];
  assign dout3      = dout_q[3];
  assign swap_count = swap_count_q;

endmodule
